// File: rtl/limn2600_bus_arbiter_pkg.sv
// Shared constants for the Limn2600 SRAM bus arbiter: FSM encodings, default
// bus widths and the largest supported requester count.
package limn2600_bus_arbiter_pkg;

    localparam int MAX_NUM_REQ = 8;
    localparam int DEFAULT_AW  = 32;
    localparam int DEFAULT_DW  = 32;

    // Encodings are shared with the SRAM and CPU bus code; do not renumber.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/limn2600_bus_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first set request bit searching
// from last+1 upward, wrapping back to last itself.
module limn2600_bus_arbiter_rr_picker
    import limn2600_bus_arbiter_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [2:0]   last,
    output logic         valid,
    output logic [2:0]   idx
);

    logic [MAX_NUM_REQ-1:0] req_pad_s;
    logic [2:0]             pos_s;

    assign req_pad_s = MAX_NUM_REQ'(req);

    // Walk candidates from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        valid = 1'b0;
        idx   = 3'd0;
        pos_s = 3'd0;
        for (int k = N; k >= 1; k--) begin
            pos_s = 3'((int'(last) + k) % N);
            idx   = req_pad_s[pos_s] ? pos_s : idx;
            valid = valid | req_pad_s[pos_s];
        end
    end

endmodule

// File: rtl/limn2600_bus_arbiter.sv
// Limn2600 SRAM bus arbiter: round-robin sharing of the single SRAM port with
// one outstanding transaction, optional bus lock and a WAIT watchdog.
module limn2600_bus_arbiter
    import limn2600_bus_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int AW      = DEFAULT_AW,
    parameter int DW      = DEFAULT_DW,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_cs,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_rdy,
    output logic                  req_err,
    output logic [DW-1:0]         req_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [DW-1:0]         mem_wdata,
    input  logic                  mem_rdy,
    input  logic [DW-1:0]         mem_rdata,
    output logic [2:0]            grant_id
);

    localparam int             WDW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
    localparam logic [WDW-1:0] WD_ONE   = WDW'(1);
    localparam logic [WDW-1:0] WD_MAX   = {WDW{1'b1}};

    logic [1:0]             state_r;
    logic [2:0]             grant_r;
    logic [2:0]             last_grant_r;
    logic                   lock_r;
    logic                   locked_valid_r;
    logic [2:0]             locked_owner_r;
    logic [WDW-1:0]         wd_cnt_r;
    logic                   mem_cs_r;
    logic                   mem_we_r;
    logic [AW-1:0]          mem_addr_r;
    logic [DW-1:0]          mem_wdata_r;
    logic [NUM_REQ-1:0]     req_rdy_r;
    logic                   req_err_r;
    logic [DW-1:0]          req_rdata_r;

    logic                   pick_valid_s;
    logic [2:0]             pick_idx_s;
    logic                   issue_s;
    logic [2:0]             issue_idx_s;
    logic [MAX_NUM_REQ-1:0] req_cs_pad_s;
    logic                   sel_we_s;
    logic                   sel_lock_s;
    logic [AW-1:0]          sel_addr_s;
    logic [DW-1:0]          sel_wdata_s;
    logic [NUM_REQ-1:0]     rdy_vec_s;
    logic                   timeout_hit_s;

    limn2600_bus_arbiter_rr_picker #(.N(NUM_REQ)) u_picker (
        .req   (req_cs),
        .last  (last_grant_r),
        .valid (pick_valid_s),
        .idx   (pick_idx_s)
    );

    assign req_cs_pad_s  = MAX_NUM_REQ'(req_cs);
    assign timeout_hit_s = (TIMEOUT != 0) && (wd_cnt_r == WD_LIMIT);

    // While a lock is held, arbitration is bypassed and only the owner may issue.
    always_comb begin
        issue_s     = 1'b0;
        issue_idx_s = 3'd0;
        if (locked_valid_r) begin
            issue_s     = req_cs_pad_s[locked_owner_r];
            issue_idx_s = locked_owner_r;
        end else begin
            issue_s     = pick_valid_s;
            issue_idx_s = pick_idx_s;
        end
    end

    // AND-OR mux of the issuing requester's fields plus the completion one-hot.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_lock_s  = 1'b0;
        sel_addr_s  = {AW{1'b0}};
        sel_wdata_s = {DW{1'b0}};
        rdy_vec_s   = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            sel_we_s     = sel_we_s    | (req_we[i]   & (issue_idx_s == 3'(i)));
            sel_lock_s   = sel_lock_s  | (req_lock[i] & (issue_idx_s == 3'(i)));
            sel_addr_s   = sel_addr_s  | ({AW{issue_idx_s == 3'(i)}} & req_addr[i*AW +: AW]);
            sel_wdata_s  = sel_wdata_s | ({DW{issue_idx_s == 3'(i)}} & req_wdata[i*DW +: DW]);
            rdy_vec_s[i] = (grant_r == 3'(i));
        end
    end

    // Transaction FSM with lock owner, watchdog and all output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            grant_r        <= 3'd0;
            last_grant_r   <= 3'(NUM_REQ - 1);
            lock_r         <= 1'b0;
            locked_valid_r <= 1'b0;
            locked_owner_r <= 3'd0;
            wd_cnt_r       <= {WDW{1'b0}};
            mem_cs_r       <= 1'b0;
            mem_we_r       <= 1'b0;
            mem_addr_r     <= {AW{1'b0}};
            mem_wdata_r    <= {DW{1'b0}};
            req_rdy_r      <= {NUM_REQ{1'b0}};
            req_err_r      <= 1'b0;
            req_rdata_r    <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_s) begin
                        mem_cs_r    <= 1'b1;
                        mem_we_r    <= sel_we_s;
                        mem_addr_r  <= sel_addr_s;
                        mem_wdata_r <= sel_wdata_s;
                        grant_r     <= issue_idx_s;
                        lock_r      <= sel_lock_s;
                        wd_cnt_r    <= {WDW{1'b0}};
                        state_r     <= ST_WAIT;
                        // Grants made under lock must not disturb round-robin order.
                        if (!locked_valid_r) begin
                            last_grant_r <= issue_idx_s;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_rdy) begin
                        mem_cs_r       <= 1'b0;
                        req_rdata_r    <= mem_rdata;
                        req_err_r      <= 1'b0;
                        req_rdy_r      <= rdy_vec_s;
                        locked_valid_r <= lock_r;
                        locked_owner_r <= grant_r;
                        state_r        <= ST_RESP;
                    end else if (timeout_hit_s) begin
                        mem_cs_r       <= 1'b0;
                        req_rdata_r    <= {DW{1'b0}};
                        req_err_r      <= 1'b1;
                        req_rdy_r      <= rdy_vec_s;
                        locked_valid_r <= 1'b0;
                        state_r        <= ST_RESP;
                    end else if (wd_cnt_r != WD_MAX) begin
                        wd_cnt_r <= wd_cnt_r + WD_ONE;
                    end
                end
                ST_RESP: begin
                    req_rdy_r   <= {NUM_REQ{1'b0}};
                    req_err_r   <= 1'b0;
                    req_rdata_r <= {DW{1'b0}};
                    state_r     <= ST_IDLE;
                end
                default: begin
                    mem_cs_r    <= 1'b0;
                    req_rdy_r   <= {NUM_REQ{1'b0}};
                    req_err_r   <= 1'b0;
                    req_rdata_r <= {DW{1'b0}};
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_cs    = mem_cs_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign req_rdy   = req_rdy_r;
    assign req_err   = req_err_r;
    assign req_rdata = req_rdata_r;
    assign grant_id  = grant_r;

endmodule

// File: tb/tb_limn2600_bus_arbiter.sv
// Directed scoreboard bench for limn2600_bus_arbiter with an address-keyed
// SRAM responder (latency and timeout behaviour chosen by address).
module tb_limn2600_bus_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NR-1:0]    req_cs    = '0;
    logic [NR-1:0]    req_we    = '0;
    logic [NR-1:0]    req_lock  = '0;
    logic [NR*AW-1:0] req_addr  = '0;
    logic [NR*DW-1:0] req_wdata = '0;
    logic [NR-1:0]    req_rdy;
    logic             req_err;
    logic [DW-1:0]    req_rdata;
    logic             mem_cs, mem_we;
    logic [AW-1:0]    mem_addr;
    logic [DW-1:0]    mem_wdata;
    logic             mem_rdy;
    logic [DW-1:0]    mem_rdata;
    logic [2:0]       grant_id;

    always #5 clk = ~clk;

    limn2600_bus_arbiter #(.NUM_REQ(NR), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_cs(req_cs), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_rdy(req_rdy), .req_err(req_err),
        .req_rdata(req_rdata), .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdy(mem_rdy), .mem_rdata(mem_rdata), .grant_id(grant_id)
    );

    // Address high nibble F: SRAM never answers; E: answers on the timeout cycle; else addr[5:4].
    function automatic int lat_of(input logic [AW-1:0] a);
        if (a[31:28] == 4'hF) return -1;
        if (a[31:28] == 4'hE) return TO;
        return int'(a[5:4]);
    endfunction

    function automatic logic [DW-1:0] rd_val(input logic [AW-1:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return a ^ 32'h5A5A_0000;
    endfunction

    int sram_cnt = 0;
    int sram_lat = 0;

    // SRAM responder, driven away from the active edge.
    always @(negedge clk) begin
        sram_lat = lat_of(mem_addr);
        if (mem_cs) begin
            if (sram_lat >= 0 && sram_cnt == sram_lat) begin
                mem_rdy   = 1'b1;
                mem_rdata = mem_we ? 32'h0 : rd_val(mem_addr);
            end else begin
                mem_rdy   = 1'b0;
                mem_rdata = 32'hBAD0_BAD0;
            end
            sram_cnt = sram_cnt + 1;
        end else begin
            sram_cnt  = 0;
            mem_rdy   = 1'b0;
            mem_rdata = 32'hBAD0_BAD0;
        end
    end

    typedef struct {
        logic          we;
        logic          lock;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    typedef struct {
        int            gid;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
        logic          err;
        int            cs_len;
    } exp_t;

    req_t pend [NR][$];
    req_t hist [NR][$];
    exp_t sb[$];

    int            checks = 0;
    int            failures = 0;
    logic          prev_cs = 1'b0;
    int            cs_len = 0;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic          cap_we;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic txn(input int i, input logic we, input logic lock,
                       input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        req_t r;
        r.we = we; r.lock = lock; r.addr = addr; r.wdata = wdata;
        pend[i].push_back(r);
        hist[i].push_back(r);
    endtask

    // Push the expected completion of requester i's next transaction.
    task automatic grant_next(input int i);
        req_t r;
        exp_t e;
        int   lat;
        r = hist[i].pop_front();
        lat = lat_of(r.addr);
        e.gid = i; e.we = r.we; e.addr = r.addr; e.wdata = r.wdata;
        if (lat < 0) begin
            e.err = 1'b1; e.rdata = 32'h0; e.cs_len = TO + 1;
        end else begin
            e.err = 1'b0; e.rdata = r.we ? 32'h0 : rd_val(r.addr); e.cs_len = lat + 1;
        end
        sb.push_back(e);
    endtask

    task automatic present(input int i);
        req_t r;
        if (pend[i].size() > 0) begin
            r = pend[i].pop_front();
            req_cs[i] = 1'b1; req_we[i] = r.we; req_lock[i] = r.lock;
            req_addr[i*AW +: AW] = r.addr;
            req_wdata[i*DW +: DW] = r.wdata;
        end else begin
            req_cs[i] = 1'b0; req_we[i] = 1'b0; req_lock[i] = 1'b0;
        end
    endtask

    task automatic kick();
        for (int i = 0; i < NR; i++) present(i);
    endtask

    task automatic mon_step();
        exp_t e;
        if (mem_cs && !prev_cs) begin
            cap_addr = mem_addr; cap_we = mem_we; cap_wdata = mem_wdata;
        end
        if (mem_cs) cs_len++;
        if (req_rdy != '0) begin
            if (sb.size() == 0) begin
                check("unexpected_rdy", 128'(req_rdy), 128'd0);
            end else begin
                e = sb.pop_front();
                check("rdy_onehot", 128'(req_rdy), 128'd1 << e.gid);
                check("grant_id", 128'(grant_id), 128'(e.gid));
                check("mem_addr", 128'(cap_addr), 128'(e.addr));
                check("mem_we", 128'(cap_we), 128'(e.we));
                check("mem_wdata", 128'(cap_wdata), 128'(e.wdata));
                check("rdata", 128'(req_rdata), 128'(e.rdata));
                check("err", 128'(req_err), 128'(e.err));
                check("cs_cycles", 128'(cs_len), 128'(e.cs_len));
            end
            cs_len = 0;
        end else begin
            check("quiet_resp", {95'd0, req_err, req_rdata}, 128'd0);
        end
        prev_cs = mem_cs;
    endtask

    task automatic run(input int budget);
        int n;
        n = 0;
        while (n < budget && !(pend[0].size() == 0 && pend[1].size() == 0 &&
                               req_cs == '0 && sb.size() == 0)) begin
            @(negedge clk);
            mon_step();
            for (int i = 0; i < NR; i++) begin
                if (req_rdy[i]) present(i);
            end
            n++;
        end
        check("sb_drained", 128'(sb.size()), 128'd0);
        check("requests_done", 128'(req_cs), 128'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            mon_step();
        end
    endtask

    initial begin
        // Reset state
        #1;
        check("reset_outputs", {req_rdy, req_err, req_rdata, mem_cs, mem_we, mem_addr,
                                mem_wdata, grant_id}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-WAIT, then req0 wins first
        txn(1, 1'b0, 1'b0, 32'h0000_0030, 32'h0);
        kick();
        idle(2);
        check("mid_wait_cs", 128'(mem_cs), 128'd1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {req_rdy, req_err, req_rdata, mem_cs, mem_we, mem_addr,
                                      mem_wdata, grant_id}, 128'd0);
        for (int i = 0; i < NR; i++) begin
            pend[i].delete();
            hist[i].delete();
        end
        req_cs = '0; req_we = '0; req_lock = '0;
        prev_cs = 1'b0; cs_len = 0;
        @(negedge clk);
        rst = 1'b0;
        txn(0, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
        txn(1, 1'b0, 1'b0, 32'h0000_0050, 32'h0);
        grant_next(0); grant_next(1);
        kick();
        run(100);

        // Single read with one-cycle issue latency
        idle(1);
        txn(0, 1'b0, 1'b0, 32'h0000_0100, 32'h0);
        grant_next(0);
        kick();
        idle(1);
        check("issue_latency_cs", 128'(mem_cs), 128'd1);
        check("issue_latency_addr", 128'(mem_addr), 128'h100);
        run(50);

        // Contention: strict alternation, req1 first since req0 was granted last
        idle(1);
        for (int k = 0; k < 4; k++) begin
            txn(0, 1'b0, 1'b0, 32'h0000_1000 + 32'(k * 16), 32'h0);
            txn(1, 1'b1, 1'b0, 32'h0000_2000 + 32'(k * 16), 32'hC0DE_0000 + 32'(k));
        end
        for (int k = 0; k < 4; k++) begin
            grant_next(1); grant_next(0);
        end
        kick();
        run(200);

        // Lock: req1 holds the bus for its locked writes and the unlocking write
        idle(1);
        for (int k = 0; k < 3; k++) txn(1, 1'b1, 1'b1, 32'h0000_3000 + 32'(k * 16), 32'hA000_0000 + 32'(k));
        txn(1, 1'b1, 1'b0, 32'h0000_3030, 32'hA000_0003);
        txn(0, 1'b0, 1'b0, 32'h0000_4000, 32'h0);
        for (int k = 0; k < 4; k++) grant_next(1);
        grant_next(0);
        kick();
        run(200);

        // Timeout under lock, then lock must be released
        idle(1);
        txn(0, 1'b0, 1'b1, 32'h0000_5000, 32'h0);
        txn(0, 1'b0, 1'b1, 32'hF000_0000, 32'h0);
        grant_next(0); grant_next(0);
        kick();
        run(100);
        idle(1);
        txn(0, 1'b0, 1'b0, 32'h0000_6000, 32'h0);
        txn(1, 1'b0, 1'b0, 32'h0000_7000, 32'h0);
        grant_next(1); grant_next(0);
        kick();
        run(100);

        // mem_rdy on the timeout cycle completes normally
        idle(1);
        txn(1, 1'b0, 1'b0, 32'hE000_0010, 32'h0);
        grant_next(1);
        kick();
        run(100);

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
